// File: rtl/audio_pkg.sv
// Shared types and arithmetic for the audio front-end frame windower.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package audio_pkg;

  localparam int SAMPLE_W = 12;
  localparam int COEF_W   = 16;
  localparam int PROD_W   = SAMPLE_W + COEF_W;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Sample times Q1.15 coefficient, rounded half up back to sample width.
  // Coefficients never exceed 32767, so the MSB is 0 and a signed view is
  // safe. |sample * coef| < 2^26, so neither the sum nor the result overflows.
  function automatic sample_t window_round(input sample_t s,
                                           input logic [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd;
    prod = PROD_W'(s) * PROD_W'($signed(c));
    rnd  = (prod + PROD_W'(16384)) >>> 15;
    return sample_t'(rnd);
  endfunction

endpackage

// File: rtl/window_coef_rom.sv
// Hann window coefficient ROM, Q1.15 unsigned, one entry per frame position.
// Latency: 1 cycle from addr to coef (registered read).
// Backpressure: coef holds its value whenever en is low.
// Ports: clk; en read enable; addr frame position; coef registered coefficient.
module window_coef_rom
  import audio_pkg::*;
#(
  parameter int N = 256
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] addr,
  output logic [COEF_W-1:0]    coef
);

  localparam real PI = 3.14159265358979323846;

  logic [COEF_W-1:0] coef_tab [N];

  // Table is fixed at elaboration; the symmetric form k/(N-1) puts zeros at
  // both ends of the frame.
  for (genvar k = 0; k < N; k++) begin : g_tab
    localparam real HANN = 0.5 * (1.0 - $cos(2.0 * PI * k / (N - 1)));
    localparam int  C    = $rtoi(32767.0 * HANN + 0.5);
    assign coef_tab[k] = COEF_W'(C);
  end

  always_ff @(posedge clk) begin
    if (en) coef <= coef_tab[addr];
  end

endmodule

// File: rtl/frame_windower.sv
// Buffers mic samples in a 2N circular RAM and streams Hann-windowed frames of N.
// Latency: first beat valid 2 cycles after launch; then 1 beat/cycle.
// Backpressure: frame_valid && !frame_ready freezes read address and both stages.
// Ports: clk, rst (sync, high); sample_in/sample_valid write side;
//   frame_data/valid/ready/first/last/index stream out; busy; sticky overrun.
module frame_windower
  import audio_pkg::*;
#(
  parameter int N         = 256,
  parameter int HOP       = 256,
  parameter bit WINDOW_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic signed [SAMPLE_W-1:0] frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       frame_first,
  output logic                       frame_last,
  output logic [$clog2(N)-1:0]       frame_index,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;
  localparam int HW = $clog2(2 * HOP + 1);

  localparam logic [PW-1:0] N_PTR  = PW'(N);
  localparam logic [AW:0]   N_CNT  = (AW + 1)'(N);
  localparam logic [AW-1:0] LAST_I = AW'(N - 1);
  localparam logic [HW-1:0] HOP_C  = HW'(HOP);
  localparam logic [HW-1:0] HOP2_C = HW'(2 * HOP);

  state_t            state, state_nxt;
  logic [PW-1:0]     wr_ptr, base, rd_addr;
  logic [AW:0]       fill_cnt, since_cnt;
  logic [HW-1:0]     hop_cnt;
  logic [AW-1:0]     rd_idx, cur_idx, s1_idx;
  logic              primed, adv, launch, issue, last_acc, s1_vld;
  sample_t           mem [2*N];
  sample_t           ram_q;
  logic [COEF_W-1:0] coef;

  assign primed   = (fill_cnt == N_CNT);
  assign adv      = !(frame_valid && !frame_ready);
  assign busy     = (state != IDLE);
  assign last_acc = frame_valid && frame_ready && frame_last;

  // Index 0 is read on the launch cycle itself, straight from the live
  // write pointer, which is what makes first-beat latency two cycles.
  assign cur_idx = launch ? '0 : rd_idx;
  assign rd_addr = launch ? (wr_ptr - N_PTR) : (base + {1'b0, rd_idx});

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (primed && (hop_cnt >= HOP_C) && adv) begin
          launch    = 1'b1;
          issue     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          issue = 1'b1;
          if (rd_idx == LAST_I) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_acc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      hop_cnt   <= '0;
      since_cnt <= '0;
      base      <= '0;
      rd_idx    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (sample_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!primed) fill_cnt <= fill_cnt + 1'b1;
      end
      if (launch) begin
        base      <= wr_ptr - N_PTR;
        rd_idx    <= AW'(1);
        // A sample landing on the launch cycle starts the next hop.
        hop_cnt   <= HW'(sample_valid);
        since_cnt <= (AW + 1)'(sample_valid);
      end else begin
        if (issue) rd_idx <= rd_idx + 1'b1;
        if (sample_valid) begin
          // A second full hop while still busy: drop the pending launch but
          // keep one hop owed so a frame starts as soon as we go idle.
          if (busy && (hop_cnt >= HOP2_C - 1'b1)) begin
            hop_cnt <= HOP_C;
            overrun <= 1'b1;
          end else if (hop_cnt < HOP2_C) begin
            hop_cnt <= hop_cnt + 1'b1;
          end
          // N writes since launch means the frame's oldest slot is reused.
          if (busy && (since_cnt < N_CNT)) begin
            since_cnt <= since_cnt + 1'b1;
            if (since_cnt == N_CNT - 1'b1) overrun <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample_valid) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (issue) ram_q <= mem[rd_addr];
  end

  window_coef_rom #(.N(N)) u_rom (
    .clk  (clk),
    .en   (issue),
    .addr (cur_idx),
    .coef (coef)
  );

  // Stage 1 tag travels alongside the RAM/ROM read registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
    end else if (adv) begin
      s1_vld <= issue;
      s1_idx <= cur_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_index <= '0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
    end else if (adv) begin
      frame_valid <= s1_vld;
      frame_data  <= WINDOW_EN ? window_round(ram_q, coef) : ram_q;
      frame_index <= s1_idx;
      frame_first <= s1_vld && (s1_idx == '0);
      frame_last  <= s1_vld && (s1_idx == LAST_I);
    end
  end

endmodule

// File: tb/tb_frame_windower.sv
module tb_frame_windower;

  localparam int  N  = 8;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  logic signed [11:0] sample_in;
  logic sample_valid;
  logic frame_ready;

  logic signed [11:0] fd [2];
  logic [2:0]         fi [2];
  logic               fv [2], ff [2], fl [2], fb [2], fo [2];

  always #50 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  relax    = 1'b0;

  // Reference model state, per DUT: 0 = HOP 8 bypass, 1 = HOP 4 windowed.
  int  w [2];
  int  hist [2][$];
  int  exp_q [2][$];
  int  bc [2];
  int  nb [2];

  for (genvar d = 0; d < 2; d++) begin : g
    frame_windower #(
      .N         (N),
      .HOP       ((d == 0) ? 8 : 4),
      .WINDOW_EN ((d == 0) ? 1'b0 : 1'b1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .frame_data   (fd[d]),
      .frame_valid  (fv[d]),
      .frame_ready  (frame_ready),
      .frame_first  (ff[d]),
      .frame_last   (fl[d]),
      .frame_index  (fi[d]),
      .busy         (fb[d]),
      .overrun      (fo[d])
    );
  end

  function automatic int hop_of(int d);
    return (d == 0) ? 8 : 4;
  endfunction

  // Hann-windowed value from the real-valued formula, rounded half up.
  function automatic int win(int s, int k);
    real c;
    c = $floor(32767.0 * 0.5 * (1.0 - $cos(2.0 * PI * k / (N - 1))) + 0.5);
    return $rtoi($floor(s * c / 32768.0 + 0.5));
  endfunction

  task automatic check(string nm, logic signed [31:0] got, logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  // Model: a frame is due after every write count N, N+HOP, N+2*HOP, ...
  // and holds the N most recent samples, oldest first.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        w[d] = 0;
        hist[d].delete();
        exp_q[d].delete();
      end else if (sample_valid) begin
        hist[d].push_back(int'(sample_in));
        w[d]++;
        if (w[d] >= N && ((w[d] - N) % hop_of(d)) == 0)
          for (int k = 0; k < N; k++)
            exp_q[d].push_back((d == 0) ? hist[d][w[d]-N+k] : win(hist[d][w[d]-N+k], k));
      end
    end
  end

  // Monitor: every accepted beat is checked for position tags and data.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        bc[d] = 0;
      end else if (fv[d] && frame_ready) begin
        check($sformatf("index_dut%0d", d), fi[d], bc[d]);
        check($sformatf("first_dut%0d", d), ff[d], (bc[d] == 0));
        check($sformatf("last_dut%0d", d), fl[d], (bc[d] == N - 1));
        if (!relax) begin
          if (exp_q[d].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat_dut%0d: got beat data %0d, required no beat", d, fd[d]);
          end else begin
            check($sformatf("data_dut%0d", d), fd[d], exp_q[d].pop_front());
          end
        end
        bc[d] = (bc[d] + 1) % N;
        nb[d]++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_sample(int v, int gap, bit rnd_ready);
    sample_valid = 1'b1;
    sample_in    = 12'(v);
    if (rnd_ready) frame_ready = 1'($urandom_range(1, 0));
    cyc();
    sample_valid = 1'b0;
    for (int i = 1; i < gap; i++) begin
      if (rnd_ready) frame_ready = 1'($urandom_range(1, 0));
      cyc();
    end
  endtask

  task automatic drain(string nm);
    bit done;
    done = 1'b0;
    frame_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc();
      done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && !fb[0] && !fb[1];
    end
    check(nm, done, 1);
  endtask

  initial begin
    int nb0 [2];
    bit hit;
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0; frame_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin bc[d] = 0; nb[d] = 0; end
    repeat (3) cyc();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid_dut%0d", d), fv[d], 0);
      check($sformatf("rst_data_dut%0d", d), fd[d], 0);
      check($sformatf("rst_index_dut%0d", d), fi[d], 0);
      check($sformatf("rst_first_dut%0d", d), ff[d], 0);
      check($sformatf("rst_last_dut%0d", d), fl[d], 0);
      check($sformatf("rst_busy_dut%0d", d), fb[d], 0);
      check($sformatf("rst_overrun_dut%0d", d), fo[d], 0);
    end
    rst = 1'b0;
    repeat (100) cyc();
    for (int d = 0; d < 2; d++) check($sformatf("idle_busy_dut%0d", d), fb[d], 0);

    // Ramp 1..16: first frame after 8, bypass DUT silent until 16.
    for (int v = 1; v <= 16; v++) put_sample(v, 8, 1'b0);
    drain("drain_ramp");

    // Constant full-scale extremes through the window.
    for (int i = 0; i < 8; i++) put_sample(2047, 8, 1'b0);
    for (int i = 0; i < 8; i++) put_sample(-2048, 8, 1'b0);
    drain("drain_const");

    // Random samples with random backpressure.
    for (int i = 0; i < 48; i++) put_sample(int'($urandom_range(4095, 0)) - 2048, 12, 1'b1);
    drain("drain_random");
    for (int d = 0; d < 2; d++) check($sformatf("no_overrun_dut%0d", d), fo[d], 0);

    // Stall the consumer while samples keep arriving.
    relax = 1'b1;
    frame_ready = 1'b0;
    for (int d = 0; d < 2; d++) nb0[d] = nb[d];
    for (int i = 0; i < 20; i++) put_sample(int'($urandom_range(4095, 0)) - 2048, 2, 1'b0);
    for (int d = 0; d < 2; d++) check($sformatf("overrun_set_dut%0d", d), fo[d], 1);
    frame_ready = 1'b1;
    repeat (80) cyc();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("overrun_sticky_dut%0d", d), fo[d], 1);
      check($sformatf("ovr_frame_done_dut%0d", d), fb[d], 0);
      check($sformatf("ovr_beats_dut%0d", d), (nb[d] - nb0[d]) >= N, 1);
    end

    rst = 1'b1; frame_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0; relax = 1'b0; frame_ready = 1'b1;
    for (int d = 0; d < 2; d++) check($sformatf("overrun_cleared_dut%0d", d), fo[d], 0);

    // Reset in the middle of a frame, right after its third beat.
    for (int v = 0; v < 7; v++) put_sample(100 + v, 8, 1'b0);
    put_sample(107, 1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (fv[1] && fi[1] == 3'd2) hit = 1'b1;
      else cyc();
    end
    check("mid_frame_reached", hit, 1);
    cyc();
    rst = 1'b1; frame_ready = 1'b0;
    cyc();
    for (int d = 0; d < 2; d++) check($sformatf("valid_after_rst_dut%0d", d), fv[d], 0);
    rst = 1'b0; frame_ready = 1'b1;
    for (int v = 0; v < 7; v++) put_sample(-300 + 50 * v, 8, 1'b0);
    for (int d = 0; d < 2; d++) check($sformatf("unprimed_busy_dut%0d", d), fb[d], 0);
    put_sample(555, 8, 1'b0);
    drain("drain_after_rst");
    check("post_rst_beats_dut1", nb[1] > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
